// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the control path and the HI/LO mul/div unit.
// The control path drives the operands; the unit returns busy/done and HI/LO.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide with the architectural HI/LO pair.
// Signed ops run on magnitudes; signs are fixed up on the final iteration.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_a;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // op[0] clear selects the signed variant of both MULT and DIV
    assign w_a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag = w_b_neg ? -bus.b : bus.b;

    assign w_mul_sum = {1'b0, r_acc_hi}
                     + (r_acc_lo[0] ? {1'b0, r_dvs} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

    assign w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_fit    = ~w_diff[WIDTH];
    assign w_div_hi = w_fit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_lo = {r_acc_lo[WIDTH-2:0], w_fit};

    always_comb begin
        w_prod   = {w_mul_hi, w_mul_lo};
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_is_div && r_div0) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else if (r_is_div) begin
            w_res_hi = r_neg_r ? -w_div_hi : w_div_hi;
            w_res_lo = r_neg_q ? -w_div_lo : w_div_lo;
        end else begin
            if (r_neg_q) w_prod = -w_prod;
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_dvs    <= '0;
            r_a      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_acc_hi <= '0;
                                r_acc_lo <= w_a_mag;
                                r_dvs    <= w_b_mag;
                                r_a      <= bus.a;
                                r_is_div <= bus.op[1];
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_div0   <= (bus.b == '0);
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= RUN;
                            end
                            3'b100:  r_hi <= bus.a;
                            3'b101:  r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    r_acc_hi <= r_is_div ? w_div_hi : w_mul_hi;
                    r_acc_lo <= r_is_div ? w_div_lo : w_mul_lo;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, corner sequences
// and random operations against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus_if();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        longint r;
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic do_muldiv(input string name, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input int inj_at,
                             input logic [2:0] inj_op,
                             input logic [31:0] inj_a);
        logic [31:0] ohi = bus_if.hi;
        logic [31:0] olo = bus_if.lo;
        int cyc = 0;
        bit stable = 1'b1;
        bit early = 1'b0;
        bus_if.start = 1'b1;
        bus_if.op = op;
        bus_if.a = a;
        bus_if.b = b;
        tick();
        bus_if.start = 1'b0;
        bus_if.op = 3'($urandom_range(0, 7));
        bus_if.a = $urandom;
        bus_if.b = $urandom;
        check({name, " done low after issue"}, 64'(bus_if.done), 64'd0);
        while (bus_if.busy === 1'b1 && cyc < 40) begin
            if (bus_if.done !== 1'b0) early = 1'b1;
            if (bus_if.hi !== ohi || bus_if.lo !== olo) stable = 1'b0;
            if (cyc == inj_at) begin
                bus_if.start = 1'b1;
                bus_if.op = inj_op;
                bus_if.a = inj_a;
            end
            tick();
            bus_if.start = 1'b0;
            cyc++;
        end
        check({name, " busy cycles"}, 64'(cyc), 64'd32);
        check({name, " hi/lo held"}, 64'(stable), 64'd1);
        check({name, " no early done"}, 64'(early), 64'd0);
        check({name, " done pulse"}, 64'(bus_if.done), 64'd1);
        check({name, " result"}, {bus_if.hi, bus_if.lo}, exp);
    endtask

    task automatic mt(input string name, input logic [2:0] op,
                      input logic [31:0] a, input logic [63:0] exp);
        bus_if.start = 1'b1;
        bus_if.op = op;
        bus_if.a = a;
        tick();
        bus_if.start = 1'b0;
        check({name, " hi/lo"}, {bus_if.hi, bus_if.lo}, exp);
        check({name, " busy"}, 64'(bus_if.busy), 64'd0);
        check({name, " done"}, 64'(bus_if.done), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prev;
        bit seen_done;

        vecs[0] = '{"mult 5*4",     3'd0, 32'd5,          32'd4,
                    64'h0000_0000_0000_0014};
        vecs[1] = '{"multu ff*ff",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,
                    64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{"mult -1*-1",   3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,
                    64'h0000_0000_0000_0001};
        vecs[3] = '{"multu big*2",  3'd1, 32'd2111222333, 32'd2,
                    64'd4222444666};
        vecs[4] = '{"div -7/2",     3'd2, 32'hFFFF_FFF9,  32'd2,
                    64'hFFFF_FFFF_FFFF_FFFD};
        vecs[5] = '{"divu 7/0",     3'd3, 32'd7,          32'd0,
                    64'h0000_0007_FFFF_FFFF};
        vecs[6] = '{"div min/-1",   3'd2, 32'h8000_0000,  32'hFFFF_FFFF,
                    64'h0000_0000_8000_0000};
        vecs[7] = '{"divu 100/7",   3'd3, 32'd100,        32'd7,
                    64'h0000_0002_0000_000E};
        vecs[8] = '{"multu 3*3 b2b", 3'd1, 32'd3,         32'd3,
                    64'h0000_0000_0000_0009};

        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op = 3'd0;
        bus_if.a = '0;
        bus_if.b = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset hi/lo", {bus_if.hi, bus_if.lo}, 64'd0);
        check("reset busy", 64'(bus_if.busy), 64'd0);
        check("reset done", 64'(bus_if.done), 64'd0);

        // each vector is issued in the done cycle of the previous one
        foreach (vecs[i])
            do_muldiv(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].exp, -1, 3'd0, 32'd0);
        tick();
        check("done single pulse", 64'(bus_if.done), 64'd0);

        mt("mthi", 3'd4, 32'h1234_5678, 64'h1234_5678_0000_0009);
        mt("mtlo", 3'd5, 32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

        mt("reserved 6", 3'd6, 32'h5555_AAAA, 64'h1234_5678_9ABC_DEF0);
        mt("reserved 7", 3'd7, 32'h5555_AAAA, 64'h1234_5678_9ABC_DEF0);

        do_muldiv("mthi during mult", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                  model(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
                  5, 3'd4, 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i == 7) ra = 32'h8000_0000;
            do_muldiv($sformatf("rand%0d op%0d", i, rop), rop, ra, rb,
                      model(rop, ra, rb), -1, 3'd0, 32'd0);
        end

        tick();
        mt("mthi pre-abort", 3'd4, 32'hCAFE_0001, {32'hCAFE_0001, bus_if.lo});
        prev = {bus_if.hi, bus_if.lo};
        bus_if.start = 1'b1;
        bus_if.op = 3'd0;
        bus_if.a = 32'h0123_4567;
        bus_if.b = 32'h89AB_CDEF;
        tick();
        bus_if.start = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (bus_if.done === 1'b1) seen_done = 1'b1;
            tick();
        end
        check("abort hi/lo held", {bus_if.hi, bus_if.lo}, prev);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort hi/lo", {bus_if.hi, bus_if.lo}, 64'd0);
        check("abort busy", 64'(bus_if.busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus_if.done === 1'b1) seen_done = 1'b1;
            tick();
        end
        check("abort no done", 64'(seen_done), 64'd0);
        check("abort hi/lo stay", {bus_if.hi, bus_if.lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
